// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared states, constants and PC helpers for pc_redirect_ctrl
package pc_redirect_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned TIMER_W = 4;

  localparam logic [PC_W-1:0] INSN_BYTES = 32'd4;
  localparam logic [PC_W-1:0] STAT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    JALR_WAIT = 2'd1,
    FLUSH     = 2'd2
  } redirect_state_e;

  typedef enum logic [1:0] {
    CLS_SEQ    = 2'd0,
    CLS_JAL    = 2'd1,
    CLS_JALR   = 2'd2,
    CLS_BRANCH = 2'd3
  } insn_class_e;

  // Decoder guarantees at most one class bit; anything else is a plain sequential op.
  function automatic insn_class_e decode_class(input logic is_jal,
                                               input logic is_jalr,
                                               input logic is_branch);
    insn_class_e cls;
    cls = CLS_SEQ;
    if (is_jal)         cls = CLS_JAL;
    else if (is_jalr)   cls = CLS_JALR;
    else if (is_branch) cls = CLS_BRANCH;
    return cls;
  endfunction

  function automatic logic [PC_W-1:0] pc_plus(input logic [PC_W-1:0] pc,
                                              input logic [PC_W-1:0] offset);
    return pc + offset;
  endfunction

  function automatic logic [PC_W-1:0] jalr_align(input logic [PC_W-1:0] target);
    return {target[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_flush_timer.sv
// rtl/pc_redirect_ctrl_flush_timer.sv - loadable 4-bit down-counter pacing the post-flush fetch hold-off
module pc_redirect_ctrl_flush_timer
  import pc_redirect_ctrl_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  localparam logic [TIMER_W-1:0] ONE = 1;

  logic [TIMER_W-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (rdy_in) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - ONE;
      end
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - next-fetch-PC scheduler with JALR stall, mispredict flush and predictor training
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ifetch_valid,
  input  logic [31:0] ifetch_pc,
  input  logic        ifetch_is_jal,
  input  logic        ifetch_is_jalr,
  input  logic        ifetch_is_branch,
  input  logic [31:0] ifetch_imm,
  input  logic        pred_taken,
  input  logic        rob_commit,
  input  logic        rob_is_jalr,
  input  logic        rob_is_branch,
  input  logic [31:0] rob_pc,
  input  logic        rob_taken,
  input  logic        rob_pred_taken,
  input  logic [31:0] rob_target,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic [31:0] pc_out,
  output logic        fetch_en,
  output logic        flush,
  output logic        btb_upd_valid,
  output logic [31:0] btb_upd_pc,
  output logic        btb_upd_taken
);

  localparam logic [TIMER_W-1:0] FLUSH_LOAD = TIMER_W'(FLUSH_CYCLES);

  redirect_state_e state;
  insn_class_e     fetch_class;

  logic        branch_commit;
  logic        mispredict;
  logic        jalr_resolve;
  logic        timer_load;
  logic        timer_done;
  logic [31:0] taken_pc;
  logic [31:0] seq_pc;
  logic [31:0] recover_pc;

  // The ROB is empty after a flush, so commits seen in FLUSH are dropped entirely.
  assign branch_commit = rob_commit && rob_is_branch && (state != FLUSH);
  assign mispredict    = branch_commit && (rob_taken != rob_pred_taken);
  assign jalr_resolve  = rob_commit && rob_is_jalr && (state == JALR_WAIT);
  assign timer_load    = rdy_in && mispredict;

  assign fetch_class = decode_class(ifetch_is_jal, ifetch_is_jalr, ifetch_is_branch);
  assign taken_pc    = pc_plus(ifetch_pc, ifetch_imm);
  assign seq_pc      = pc_plus(ifetch_pc, INSN_BYTES);
  assign recover_pc  = rob_taken ? rob_target : pc_plus(rob_pc, INSN_BYTES);

  pc_redirect_ctrl_flush_timer u_flush_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .load     (timer_load),
    .load_val (FLUSH_LOAD),
    .done     (timer_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= RUN;
      pc_out        <= RESET_PC;
      fetch_en      <= TRUE;
      flush         <= FALSE;
      btb_upd_valid <= FALSE;
      btb_upd_pc    <= '0;
      btb_upd_taken <= FALSE;
    end else begin
      flush         <= FALSE;
      btb_upd_valid <= FALSE;
      if (rdy_in) begin
        if (branch_commit) begin
          btb_upd_valid <= TRUE;
          btb_upd_pc    <= rob_pc;
          btb_upd_taken <= rob_taken;
        end
        // Mispredict outranks everything: a pending JALR or same-cycle fetch is on the wrong path.
        if (mispredict) begin
          pc_out   <= recover_pc;
          flush    <= TRUE;
          fetch_en <= FALSE;
          state    <= FLUSH;
        end else begin
          case (state)
            RUN: begin
              if (ifetch_valid) begin
                case (fetch_class)
                  CLS_JAL:    pc_out <= taken_pc;
                  CLS_JALR: begin
                    fetch_en <= FALSE;
                    state    <= JALR_WAIT;
                  end
                  CLS_BRANCH: pc_out <= pred_taken ? taken_pc : seq_pc;
                  default:    pc_out <= seq_pc;
                endcase
              end
            end
            JALR_WAIT: begin
              if (jalr_resolve) begin
                pc_out   <= jalr_align(rob_target);
                fetch_en <= TRUE;
                state    <= RUN;
              end
            end
            FLUSH: begin
              if (timer_done) begin
                fetch_en <= TRUE;
                state    <= RUN;
              end
            end
            default: begin
              fetch_en <= TRUE;
              state    <= RUN;
            end
          endcase
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (rdy_in) begin
      if (branch_commit && (stat_branches != STAT_MAX)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != STAT_MAX)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - self-checking bench for pc_redirect_ctrl against a behavioural model
module tb_pc_redirect_ctrl;

  localparam int FC = 2;

  logic        clk_in, rst_in, rdy_in;
  logic        ifetch_valid, ifetch_is_jal, ifetch_is_jalr, ifetch_is_branch, pred_taken;
  logic [31:0] ifetch_pc, ifetch_imm;
  logic        rob_commit, rob_is_jalr, rob_is_branch, rob_taken, rob_pred_taken;
  logic [31:0] rob_pc, rob_target;
  logic [31:0] pc_out, btb_upd_pc;
  logic        fetch_en, flush, btb_upd_valid, btb_upd_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected outputs after the next edge
  logic [31:0] m_pc, m_upd_pc;
  logic        m_fe, m_flush, m_upd_v, m_upd_t;
  bit          m_waiting, m_flushing;
  int          m_hold;
  longint      m_nbr, m_nmis;

  pc_redirect_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ifetch_valid(ifetch_valid), .ifetch_pc(ifetch_pc),
    .ifetch_is_jal(ifetch_is_jal), .ifetch_is_jalr(ifetch_is_jalr),
    .ifetch_is_branch(ifetch_is_branch), .ifetch_imm(ifetch_imm),
    .pred_taken(pred_taken), .rob_commit(rob_commit), .rob_is_jalr(rob_is_jalr),
    .rob_is_branch(rob_is_branch), .rob_pc(rob_pc), .rob_taken(rob_taken),
    .rob_pred_taken(rob_pred_taken), .rob_target(rob_target),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .pc_out(pc_out), .fetch_en(fetch_en), .flush(flush),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc), .btb_upd_taken(btb_upd_taken)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    rst_in = 0; rdy_in = 1;
    ifetch_valid = 0; ifetch_pc = 0; ifetch_is_jal = 0; ifetch_is_jalr = 0;
    ifetch_is_branch = 0; ifetch_imm = 0; pred_taken = 0;
    rob_commit = 0; rob_is_jalr = 0; rob_is_branch = 0; rob_pc = 0;
    rob_taken = 0; rob_pred_taken = 0; rob_target = 0;
  endtask

  task automatic model_step();
    bit br, mis;
    if (rst_in) begin
      m_pc = 32'h0; m_fe = 1; m_flush = 0; m_upd_v = 0; m_upd_pc = 0; m_upd_t = 0;
      m_waiting = 0; m_flushing = 0; m_hold = 0; m_nbr = 0; m_nmis = 0;
      return;
    end
    m_flush = 0; m_upd_v = 0;
    if (!rdy_in) return;
    br  = rob_commit && rob_is_branch && !m_flushing;
    mis = br && (rob_taken != rob_pred_taken);
    if (br) begin
      m_upd_v = 1; m_upd_pc = rob_pc; m_upd_t = rob_taken;
      if (m_nbr < 64'hFFFF_FFFF) m_nbr++;
    end
    if (mis) begin
      if (m_nmis < 64'hFFFF_FFFF) m_nmis++;
      m_pc = rob_taken ? rob_target : rob_pc + 32'd4;
      m_flush = 1; m_fe = 0; m_flushing = 1; m_waiting = 0;
      m_hold = FC;  // further fetch-off cycles after the flush cycle
    end else if (m_flushing) begin
      if (m_hold == 0) begin m_flushing = 0; m_fe = 1; end
      else m_hold--;
    end else if (m_waiting) begin
      if (rob_commit && rob_is_jalr) begin
        m_pc = rob_target & 32'hFFFF_FFFE; m_fe = 1; m_waiting = 0;
      end
    end else if (ifetch_valid) begin
      if (ifetch_is_jal) m_pc = ifetch_pc + ifetch_imm;
      else if (ifetch_is_jalr) begin m_fe = 0; m_waiting = 1; end
      else if (ifetch_is_branch && pred_taken) m_pc = ifetch_pc + ifetch_imm;
      else m_pc = ifetch_pc + 32'd4;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 1; rdy_in = 0;
    tick(); tick();
    clear_inputs();
    n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    n_tests++; if (fetch_en !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_en got %b exp 1", fetch_en); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
    n_tests++; if (btb_upd_valid !== 1'b0 || btb_upd_pc !== 32'h0 || btb_upd_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_btb got v=%b pc=%h t=%b exp 0/0/0", btb_upd_valid, btb_upd_pc, btb_upd_taken); end
  endtask

  task automatic test_jal_jalr();
    clear_inputs(); ifetch_valid = 1; ifetch_pc = 32'h100; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h104 || fetch_en !== 1'b1) begin n_fail++;
      $display("FAIL alu_seq got pc=%h fe=%b exp pc=104 fe=1", pc_out, fetch_en); end
    ifetch_valid = 1; ifetch_pc = 32'h200; ifetch_is_jal = 1; ifetch_imm = 32'hFFFF_FFF0; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h1F0) begin n_fail++; $display("FAIL jal_target got %h exp 1f0", pc_out); end
    ifetch_valid = 1; ifetch_pc = 32'h300; ifetch_is_jalr = 1; tick(); clear_inputs();
    n_tests++; if (fetch_en !== 1'b0 || pc_out !== 32'h1F0) begin n_fail++;
      $display("FAIL jalr_stall got pc=%h fe=%b exp pc=1f0 fe=0", pc_out, fetch_en); end
    ifetch_valid = 1; ifetch_pc = 32'h900; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h1F0 || fetch_en !== 1'b0) begin n_fail++;
      $display("FAIL jalr_wait_ignores_fetch got pc=%h fe=%b exp pc=1f0 fe=0", pc_out, fetch_en); end
    rob_commit = 1; rob_is_jalr = 1; rob_target = 32'h1235; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h1234 || fetch_en !== 1'b1) begin n_fail++;
      $display("FAIL jalr_resolve got pc=%h fe=%b exp pc=1234 fe=1", pc_out, fetch_en); end
  endtask

  task automatic test_mispredict();
    int low;
    clear_inputs();
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h400; rob_taken = 1; rob_pred_taken = 0; rob_target = 32'h480;
    tick(); clear_inputs();
    n_tests++; if (flush !== 1'b1 || pc_out !== 32'h480 || fetch_en !== 1'b0) begin n_fail++;
      $display("FAIL mispredict_redirect got fl=%b pc=%h fe=%b exp 1/480/0", flush, pc_out, fetch_en); end
    n_tests++; if (btb_upd_valid !== 1'b1 || btb_upd_pc !== 32'h400 || btb_upd_taken !== 1'b1) begin n_fail++;
      $display("FAIL mispredict_train got v=%b pc=%h t=%b exp 1/400/1", btb_upd_valid, btb_upd_pc, btb_upd_taken); end
    low = 1;
    for (int i = 0; i < 12 && fetch_en === 1'b0; i++) begin
      ifetch_valid = 1; ifetch_pc = 32'hA00; ifetch_is_jal = 1; ifetch_imm = 32'h40;
      tick();
      n_tests++; if (flush !== 1'b0 || btb_upd_valid !== 1'b0) begin n_fail++;
        $display("FAIL flush_single_pulse got fl=%b v=%b exp 0/0", flush, btb_upd_valid); end
      if (fetch_en === 1'b0) low++;
    end
    clear_inputs();
    n_tests++; if (low !== FC + 1) begin n_fail++; $display("FAIL flush_hold_len got %0d exp %0d", low, FC + 1); end
    n_tests++; if (pc_out !== 32'h480) begin n_fail++; $display("FAIL flush_fetch_ignored got %h exp 480", pc_out); end
  endtask

  task automatic test_same_cycle();
    clear_inputs();
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h500; rob_taken = 0; rob_pred_taken = 1; rob_target = 32'h7770;
    ifetch_valid = 1; ifetch_pc = 32'h600; ifetch_is_jal = 1; ifetch_imm = 32'h40;
    tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h504 || flush !== 1'b1) begin n_fail++;
      $display("FAIL same_cycle_mispredict got pc=%h fl=%b exp 504/1", pc_out, flush); end
    for (int i = 0; i < 12 && fetch_en === 1'b0; i++) tick();
    n_tests++; if (pc_out !== 32'h504 || fetch_en !== 1'b1) begin n_fail++;
      $display("FAIL same_cycle_jal_discarded got pc=%h fe=%b exp 504/1", pc_out, fetch_en); end
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h700; rob_taken = 1; rob_pred_taken = 1; rob_target = 32'h780;
    ifetch_valid = 1; ifetch_pc = 32'h800;
    tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h804 || flush !== 1'b0 || btb_upd_valid !== 1'b1 || btb_upd_pc !== 32'h700) begin n_fail++;
      $display("FAIL correct_commit_with_fetch got pc=%h fl=%b v=%b upc=%h exp 804/0/1/700", pc_out, flush, btb_upd_valid, btb_upd_pc); end
  endtask

  task automatic test_jalr_wait_mispredict_pause();
    clear_inputs(); ifetch_valid = 1; ifetch_pc = 32'h300; ifetch_is_jalr = 1; tick(); clear_inputs();
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h440; rob_taken = 0; rob_pred_taken = 1; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h444 || flush !== 1'b1 || fetch_en !== 1'b0) begin n_fail++;
      $display("FAIL jalr_wait_mispredict got pc=%h fl=%b fe=%b exp 444/1/0", pc_out, flush, fetch_en); end
    tick();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0; rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h990; rob_taken = 1; rob_pred_taken = 0;
      tick();
      n_tests++; if (fetch_en !== 1'b0 || flush !== 1'b0 || btb_upd_valid !== 1'b0 || pc_out !== 32'h444) begin n_fail++;
        $display("FAIL rdy_low_freeze got fe=%b fl=%b v=%b pc=%h exp 0/0/0/444", fetch_en, flush, btb_upd_valid, pc_out); end
    end
    clear_inputs(); tick();
    n_tests++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL timer_frozen got fe=%b exp 0", fetch_en); end
    tick();
    n_tests++; if (fetch_en !== 1'b1 || pc_out !== 32'h444) begin n_fail++;
      $display("FAIL flush_back_to_run got fe=%b pc=%h exp 1/444", fetch_en, pc_out); end
  endtask

  task automatic test_wrap_and_reset_mid();
    clear_inputs(); ifetch_valid = 1; ifetch_pc = 32'hFFFF_FFFC; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL pc_wrap_seq got %h exp 0", pc_out); end
    ifetch_valid = 1; ifetch_pc = 32'hFFFF_FFF0; ifetch_is_branch = 1; pred_taken = 1; ifetch_imm = 32'h20;
    tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL pc_wrap_branch got %h exp 10", pc_out); end
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h40; rob_taken = 1; rob_pred_taken = 0; rob_target = 32'h88;
    tick(); clear_inputs();
    rst_in = 1; rdy_in = 0; tick(); clear_inputs();
    n_tests++; if (pc_out !== 32'h0 || fetch_en !== 1'b1 || flush !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid_flush got pc=%h fe=%b fl=%b exp 0/1/0", pc_out, fetch_en, flush); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    clear_inputs(); rst_in = 1; tick(); clear_inputs();
    rob_commit = 1; rob_is_branch = 1; rob_pc = 32'h10; rob_taken = 1; rob_pred_taken = 1; tick();
    rob_taken = 0; rob_pred_taken = 0; tick();
    rob_taken = 1; rob_pred_taken = 0; rob_target = 32'h50; tick(); clear_inputs();
    n_tests++; if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1) begin n_fail++;
      $display("FAIL stats got br=%0d mis=%0d exp 3/1", stat_branches, stat_mispredicts); end
    for (int i = 0; i < 12 && fetch_en === 1'b0; i++) tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear_inputs();
      rdy_in = ($urandom_range(0, 9) != 0);
      rst_in = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1) == 1) begin
        int cls;
        ifetch_valid = 1;
        ifetch_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        ifetch_imm = ($urandom_range(0, 1) == 1) ? $urandom() : (32'($urandom_range(0, 255)) - 32'd128);
        cls = $urandom_range(0, 3);
        ifetch_is_jal = (cls == 1); ifetch_is_jalr = (cls == 2); ifetch_is_branch = (cls == 3);
        pred_taken = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 9) < 3) begin
        rob_commit = 1;
        if (m_waiting && $urandom_range(0, 1) == 1) rob_is_jalr = 1;
        else rob_is_branch = 1;
        rob_pc = $urandom() & 32'hFFFF_FFFC;
        rob_taken = $urandom_range(0, 1);
        rob_pred_taken = ($urandom_range(0, 2) == 0) ? ~rob_taken : rob_taken;
        rob_target = $urandom();
      end
      tick();
      n_tests++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h exp %h", i, pc_out, m_pc); end
      n_tests++; if (fetch_en !== m_fe) begin n_fail++; $display("FAIL rand_fetch_en cyc %0d got %b exp %b", i, fetch_en, m_fe); end
      n_tests++; if (flush !== m_flush) begin n_fail++; $display("FAIL rand_flush cyc %0d got %b exp %b", i, flush, m_flush); end
      n_tests++; if (btb_upd_valid !== m_upd_v || btb_upd_pc !== m_upd_pc || btb_upd_taken !== m_upd_t) begin n_fail++;
        $display("FAIL rand_btb cyc %0d got %b/%h/%b exp %b/%h/%b", i, btb_upd_valid, btb_upd_pc, btb_upd_taken, m_upd_v, m_upd_pc, m_upd_t); end
`ifdef BRANCH_STATS_EN
      n_tests++; if (stat_branches !== 32'(m_nbr) || stat_mispredicts !== 32'(m_nmis)) begin n_fail++;
        $display("FAIL rand_stats cyc %0d got %0d/%0d exp %0d/%0d", i, stat_branches, stat_mispredicts, m_nbr, m_nmis); end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk_in);
    test_reset();
    test_jal_jalr();
    test_mispredict();
    test_same_cycle();
    test_jalr_wait_mispredict_pause();
    test_wrap_and_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
